// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a sampled Johnson code to binary, checks legality and succession, tracks lock and saturating errors (clk, reset_n, valid, code -> count, count_valid, illegal, seq_err, locked, err_cnt)
module johnson_decoder #(
  parameter int N = 8,
  parameter int LOCK_CNT = 3,
  localparam int W = $clog2(2 * N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         valid,
  input  logic [N-1:0] code,
  output logic [W-1:0] count,
  output logic         count_valid,
  output logic         illegal,
  output logic         seq_err,
  output logic         locked,
  output logic [7:0]   err_cnt
);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [W-1:0] count_q, count_d, dec, nxt;
  logic count_valid_q, count_valid_d, illegal_q, illegal_d, seq_err_q, seq_err_d, locked_q, locked_d;
  logic [7:0] err_q, err_d;
  logic [N-1:0] t;
  logic legal;
  always_comb begin
    t = code[N-1] ? ~code : code;
    legal = (t & (t + N'(1))) == '0;
    dec = code[N-1] ? W'(N) : '0;
    for (int i = 0; i < N; i++) dec = dec + W'(t[i]);
    nxt = count_q == W'(2 * N - 1) ? '0 : count_q + W'(1);
  end
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    count_d = count_q;
    count_valid_d = 1'b0;
    illegal_d = valid & ~legal;
    seq_err_d = 1'b0;
    if (valid && legal) begin
      count_d = dec;
      count_valid_d = 1'b1;
      if (state_q == HUNT) begin
        state_d = CHECK;
        run_d = '0;
      end else if (dec != nxt) begin
        seq_err_d = 1'b1;
        state_d = CHECK;
        run_d = '0;
      end else if (state_q == CHECK) begin
        run_d = run_q + 4'd1;
        state_d = run_d == 4'(LOCK_CNT) ? LOCKED : CHECK;
      end
    end else if (valid) begin
      state_d = HUNT;
      run_d = '0;
    end
    locked_d = state_d == LOCKED;
    err_d = (illegal_d | seq_err_d) && err_q != 8'hFF ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      run_q <= '0;
      count_q <= '0;
      count_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
      locked_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      count_q <= count_d;
      count_valid_q <= count_valid_d;
      illegal_q <= illegal_d;
      seq_err_q <= seq_err_d;
      locked_q <= locked_d;
      err_q <= err_d;
    end
  end
  assign count = count_q;
  assign count_valid = count_valid_q;
  assign illegal = illegal_q;
  assign seq_err = seq_err_q;
  assign locked = locked_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: table vectors, corner sequences and random stimulus against a reference model
module tb_johnson_decoder;
  localparam int LC = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid = 1'b0;
  logic [7:0] code = '0;
  logic [3:0] count;
  logic count_valid, illegal, seq_err, locked;
  logic [7:0] err_cnt;
  int checks = 0;
  int failures = 0;
  logic [7:0] seq [16];
  int m_state, m_run, m_prev, m_count, m_cv, m_ill, m_se, m_err;
  typedef struct {int v; int c; int cnt; int cv; int ill; int se; int lk; int err;} row_t;
  row_t tbl [36];
  int sk [29] = '{0, 1, 2, 3, 4, 5, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 10, 11, 12};

  johnson_decoder #(.N(8), .LOCK_CNT(LC)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .code(code), .count(count),
    .count_valid(count_valid), .illegal(illegal), .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int find(input logic [7:0] c);
    for (int k = 0; k < 16; k++) if (seq[k] == c) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_prev = 0; m_count = 0; m_cv = 0; m_ill = 0; m_se = 0; m_err = 0;
  endtask

  task automatic step(input int v, input logic [7:0] c);
    int idx;
    valid = v[0];
    code = c;
    @(posedge clk);
    #1;
    m_cv = 0; m_ill = 0; m_se = 0;
    if (v != 0) begin
      idx = find(c);
      if (idx < 0) begin
        m_ill = 1;
        m_state = 0;
      end else begin
        m_count = idx;
        m_cv = 1;
        if (m_state == 0) begin
          m_state = 1; m_run = 0;
        end else if (idx == (m_prev + 1) % 16) begin
          if (m_state == 1) begin
            m_run++;
            if (m_run == LC) m_state = 2;
          end
        end else begin
          m_se = 1; m_state = 1; m_run = 0;
        end
        m_prev = idx;
      end
      if ((m_ill | m_se) != 0 && m_err < 255) m_err++;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".count"}, count, m_count);
    chk({tag, ".count_valid"}, count_valid, m_cv);
    chk({tag, ".illegal"}, illegal, m_ill);
    chk({tag, ".seq_err"}, seq_err, m_se);
    chk({tag, ".locked"}, locked, m_state == 2 ? 1 : 0);
    chk({tag, ".err_cnt"}, err_cnt, m_err);
  endtask

  task automatic cmp_zero(input string tag);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".count_valid"}, count_valid, 0);
    chk({tag, ".illegal"}, illegal, 0);
    chk({tag, ".seq_err"}, seq_err, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    valid = 1'b0;
    #3 reset_n = 1'b0;
    #1 cmp_zero(tag);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_illegal();
    logic [7:0] c;
    do c = 8'($urandom); while (find(c) >= 0);
    return c;
  endfunction

  initial begin
    logic [7:0] q;
    q = '0;
    for (int k = 0; k < 16; k++) begin
      seq[k] = q;
      q = {q[6:0], ~q[7]};
    end
    for (int i = 0; i < 33; i++) tbl[i] = '{1, int'(seq[i % 16]), i % 16, 1, 0, 0, i >= 3 ? 1 : 0, 0};
    tbl[33] = '{1, 'h50, 0, 0, 1, 0, 0, 1};
    tbl[34] = '{0, 'h00, 0, 0, 0, 0, 0, 1};
    tbl[35] = '{1, 'h01, 1, 1, 0, 0, 0, 1};
    model_reset();
    #12 cmp_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step(tbl[i].v, 8'(tbl[i].c));
      chk($sformatf("tbl%0d.count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d.count_valid", i), count_valid, tbl[i].cv);
      chk($sformatf("tbl%0d.illegal", i), illegal, tbl[i].ill);
      chk($sformatf("tbl%0d.seq_err", i), seq_err, tbl[i].se);
      chk($sformatf("tbl%0d.locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d.err_cnt", i), err_cnt, tbl[i].err);
    end
    do_reset("rst_skip");
    for (int i = 0; i < 29; i++) begin
      step(1, seq[sk[i]]);
      cmp_model($sformatf("skip%0d", i));
      if (i == 6 || i == 25) begin
        chk("skip.seq_err", seq_err, 1);
        chk("skip.locked", locked, 0);
        chk("skip.err_cnt", err_cnt, i == 6 ? 1 : 2);
      end
      if (i == 28) chk("skip.relock", locked, 1);
    end
    do_reset("rst_gap");
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i]);
      cmp_model($sformatf("gapv%0d", i));
      if (i == 2) chk("gap.prelock", locked, 0);
      if (i == 3) chk("gap.lock", locked, 1);
      step(0, 8'($urandom));
      cmp_model($sformatf("gapi%0d", i));
      chk("gap.idle_pulse", {29'd0, count_valid, illegal, seq_err}, 0);
    end
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      c = r < 70 ? seq[(m_prev + 1) % 16] : r < 85 ? seq[$urandom_range(0, 15)] : 8'($urandom);
      step($urandom_range(0, 9) < 8 ? 1 : 0, c);
      cmp_model($sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 300; i++) begin
      step(1, rand_illegal());
      cmp_model($sformatf("sat%0d", i));
    end
    chk("sat.err_cnt", err_cnt, 255);
    step(1, seq[0]);
    step(1, seq[1]);
    step(1, seq[2]);
    step(1, seq[3]);
    cmp_model("sat.relock");
    chk("sat.locked", locked, 1);
    chk("sat.err_hold", err_cnt, 255);
    do_reset("rst_mid");
    step(1, seq[7]);
    cmp_model("post_rst");
    chk("post_rst.count", count, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
